// File: rtl/tile_irq_ctrl.sv
// Tile-side interrupt source: latches event edges as pending and drives channel/NMI requests to the Dock IRQ router.
// Build option ACK_AUTOCLR_EN: capturing a vector also retires the captured event's pending bit.
//   state | meaning
//   IDLE  | no vector held, waiting for router slot_ack
//   ACKED | VECTOR valid, waiting for firmware read or event retirement
module tile_irq_ctrl #(
    parameter int NUM_EVENTS      = 8,
    parameter int NUM_TILE_INT_CH = 2,
    parameter int NMI_EVT         = 7,
    parameter int CFG_ADDR_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_EVENTS-1:0]      evt_in,
    output logic [NUM_TILE_INT_CH-1:0] tile_int_req,
    output logic                       tile_nmi_req,
    input  logic                       slot_ack,
    input  logic                       cfg_wr_en,
    input  logic                       cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [7:0]                 cfg_wdata,
    output logic [7:0]                 cfg_rdata,
    output logic                       ack_state
);

    typedef enum logic {IDLE, ACKED} state_t;

    state_t                     state;
    logic [NUM_EVENTS-1:0]      sync1, sync2, sync3, evt_edge;
    logic [NUM_EVENTS-1:0]      pending, enable;
    logic [1:0]                 chmap [NUM_EVENTS];
    logic                       nmi_en;
    logic [7:0]                 vector;
    logic [NUM_EVENTS-1:0]      vec_onehot;
    logic [NUM_TILE_INT_CH-1:0] req_nxt;
    logic                       nmi_nxt;
    logic [NUM_EVENTS-1:0]      w1c_mask, autoclr_mask, sel_onehot;
    logic [2:0]                 sel_ch;
    logic [3:0]                 sel_evt;
    logic                       ch_found, evt_found;
    logic                       capture, vec_rd, evt_retired;
    logic [7:0]                 rd_mux;

    assign evt_edge  = sync2 & ~sync3;
    assign capture   = slot_ack && (|tile_int_req);
    assign vec_rd    = cfg_rd_en && (cfg_addr == CFG_ADDR_WIDTH'(2));
    assign w1c_mask  = (cfg_wr_en && cfg_addr == CFG_ADDR_WIDTH'(0)) ? cfg_wdata[NUM_EVENTS-1:0] : '0;
    assign ack_state = (state == ACKED);

`ifdef ACK_AUTOCLR_EN
    assign autoclr_mask = (state == IDLE && capture) ? sel_onehot : '0;
    assign evt_retired  = 1'b0;
`else
    assign autoclr_mask = '0;
    assign evt_retired  = ~|(pending & vec_onehot);
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= evt_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // The NMI event never feeds a maskable channel, even if enabled and mapped.
    always_comb begin
        req_nxt = '0;
        nmi_nxt = 1'b0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (e == NMI_EVT) begin
                nmi_nxt = pending[e] & nmi_en;
            end else begin
                for (int c = 0; c < NUM_TILE_INT_CH; c++) begin
                    if (pending[e] && enable[e] && chmap[e] == 2'(c)) req_nxt[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_ch     = '0;
        sel_evt    = '0;
        sel_onehot = '0;
        ch_found   = 1'b0;
        evt_found  = 1'b0;
        for (int c = 0; c < NUM_TILE_INT_CH; c++) begin
            if (!ch_found && tile_int_req[c]) begin
                ch_found = 1'b1;
                sel_ch   = 3'(c);
            end
        end
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (!evt_found && e != NMI_EVT && pending[e] && enable[e] && chmap[e] == sel_ch[1:0]) begin
                evt_found     = 1'b1;
                sel_evt       = 4'(e);
                sel_onehot[e] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (cfg_addr == CFG_ADDR_WIDTH'(0)) rd_mux[NUM_EVENTS-1:0] = pending;
        if (cfg_addr == CFG_ADDR_WIDTH'(1)) rd_mux[NUM_EVENTS-1:0] = enable;
        if (cfg_addr == CFG_ADDR_WIDTH'(2)) rd_mux = vector;
        if (cfg_addr == CFG_ADDR_WIDTH'(3)) rd_mux[0] = nmi_en;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if (cfg_addr == CFG_ADDR_WIDTH'(16 + e)) rd_mux[1:0] = chmap[e];
        end
    end

    // A fresh edge wins over a same-cycle W1C or auto-clear.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pending      <= '0;
            enable       <= '0;
            nmi_en       <= 1'b0;
            tile_int_req <= '0;
            tile_nmi_req <= 1'b0;
            cfg_rdata    <= '0;
            for (int e = 0; e < NUM_EVENTS; e++) chmap[e] <= '0;
        end else begin
            pending      <= (pending & ~w1c_mask & ~autoclr_mask) | evt_edge;
            tile_int_req <= req_nxt;
            tile_nmi_req <= nmi_nxt;
            if (cfg_rd_en) cfg_rdata <= rd_mux;
            if (cfg_wr_en) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(1)) enable <= cfg_wdata[NUM_EVENTS-1:0];
                if (cfg_addr == CFG_ADDR_WIDTH'(3)) nmi_en <= cfg_wdata[0];
                for (int e = 0; e < NUM_EVENTS; e++) begin
                    if (cfg_addr == CFG_ADDR_WIDTH'(16 + e)) chmap[e] <= cfg_wdata[1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            vector     <= '0;
            vec_onehot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state      <= ACKED;
                        vector     <= {1'b1, sel_ch, sel_evt};
                        vec_onehot <= sel_onehot;
                    end
                end
                ACKED: begin
                    if (vec_rd || evt_retired) begin
                        state     <= IDLE;
                        vector[7] <= 1'b0;
                    end else if (capture) begin
                        vector     <= {1'b1, sel_ch, sel_evt};
                        vec_onehot <= sel_onehot;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_irq_ctrl.sv
// Directed bench for tile_irq_ctrl: edge latching, request mapping, NMI path, ack/vector handshake.
module tb_tile_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] evt_in = '0;
    logic [1:0] tile_int_req;
    logic       tile_nmi_req;
    logic       slot_ack = 1'b0;
    logic       cfg_wr_en = 1'b0;
    logic       cfg_rd_en = 1'b0;
    logic [7:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [7:0] cfg_rdata;
    logic       ack_state;
    logic [7:0] rd;

    int n_chk = 0;
    int n_err = 0;

    tile_irq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .evt_in(evt_in),
        .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req),
        .slot_ack(slot_ack), .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .ack_state(ack_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
        cfg_rd_en = 1'b1; cfg_addr = a;
        tick(1);
        cfg_rd_en = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic ack_pulse();
        slot_ack = 1'b1;
        tick(1);
        slot_ack = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("rst_int_req", {6'b0, tile_int_req}, 8'h00);
        chk("rst_nmi_req", {7'b0, tile_nmi_req}, 8'h00);
        chk("rst_ack_state", {7'b0, ack_state}, 8'h00);
        chk("rst_rdata", cfg_rdata, 8'h00);
        reg_rd(8'h00, rd); chk("rst_pending", rd, 8'h00);
        reg_rd(8'h01, rd); chk("rst_enable", rd, 8'h00);
        reg_rd(8'h02, rd); chk("rst_vector", rd, 8'h00);

        // single event on channel 0, 3-clk latch latency
        reg_wr(8'h01, 8'h01);
        reg_wr(8'h10, 8'h00);
        evt_in[0] = 1'b1;
        tick(2);
        reg_rd(8'h00, rd); chk("pend_edge3_old", rd, 8'h00);
        chk("req_before", {6'b0, tile_int_req}, 8'h00);
        reg_rd(8'h00, rd); chk("pend_latched", rd, 8'h01);
        chk("req_ch0", {6'b0, tile_int_req}, 8'h01);
        reg_wr(8'h00, 8'h01);
        chk("req_hold_w1c", {6'b0, tile_int_req}, 8'h01);
        tick(1);
        chk("req_drop_w1c", {6'b0, tile_int_req}, 8'h00);
        reg_rd(8'h00, rd); chk("level_no_reset", rd, 8'h00);
        evt_in[0] = 1'b0;

        // two events on channel 1, ack captures lowest event
        reg_wr(8'h01, 8'h06);
        reg_wr(8'h11, 8'h01);
        reg_wr(8'h12, 8'h01);
        evt_in[2] = 1'b1;
        tick(1);
        evt_in[1] = 1'b1;
        tick(5);
        chk("req_ch1", {6'b0, tile_int_req}, 8'h02);
        ack_pulse();
        chk("acked", {7'b0, ack_state}, 8'h01);
        reg_rd(8'h02, rd); chk("vector", rd, 8'h91);
        chk("ack_exit_read", {7'b0, ack_state}, 8'h00);
        reg_rd(8'h00, rd);
`ifdef ACK_AUTOCLR_EN
        chk("pend_after_ack", rd, 8'h04);
`else
        chk("pend_after_ack", rd, 8'h06);
`endif
        chk("req_ch1_hold", {6'b0, tile_int_req}, 8'h02);
`ifndef ACK_AUTOCLR_EN
        ack_pulse();
        chk("reacked", {7'b0, ack_state}, 8'h01);
        reg_wr(8'h00, 8'h02);
        tick(1);
        chk("ack_exit_retire", {7'b0, ack_state}, 8'h00);
`endif
        reg_wr(8'h00, 8'h06);
        evt_in = '0;
        tick(3);

        // NMI path
        reg_wr(8'h03, 8'h01);
        reg_wr(8'h01, 8'h86);
        evt_in[7] = 1'b1;
        tick(4);
        chk("nmi_req", {7'b0, tile_nmi_req}, 8'h01);
        chk("nmi_no_int", {6'b0, tile_int_req}, 8'h00);
        ack_pulse();
        chk("nmi_ack_idle", {7'b0, ack_state}, 8'h00);
        reg_wr(8'h03, 8'h00);
        tick(1);
        chk("nmi_masked", {7'b0, tile_nmi_req}, 8'h00);
        reg_rd(8'h00, rd); chk("nmi_pending", rd, 8'h80);
        reg_wr(8'h00, 8'h80);
        evt_in[7] = 1'b0;

        // out-of-range channel and set/clear collision
        reg_wr(8'h13, 8'h03);
        reg_wr(8'h01, 8'h08);
        evt_in[3] = 1'b1;
        tick(4);
        reg_rd(8'h00, rd); chk("ch3_pending", rd, 8'h08);
        chk("ch3_no_req", {6'b0, tile_int_req}, 8'h00);
        reg_rd(8'h13, rd); chk("chmap3_rd", rd, 8'h03);
        evt_in[3] = 1'b0;
        reg_wr(8'h00, 8'h08);
        reg_rd(8'h00, rd); chk("w1c_only", rd, 8'h00);
        tick(2);
        evt_in[3] = 1'b1;
        tick(2);
        reg_wr(8'h00, 8'h08);
        reg_rd(8'h00, rd); chk("collision", rd, 8'h08);

        reg_wr(8'h05, 8'hff);
        reg_rd(8'h05, rd); chk("unmapped", rd, 8'h00);
        reg_rd(8'h03, rd); chk("ctrl_rd", rd, 8'h00);

        // remap to channel 0, then async reset mid-operation
        reg_wr(8'h13, 8'h00);
        tick(1);
        chk("remap_req", {6'b0, tile_int_req}, 8'h01);
        rst_n = 1'b1;
        #2;
        chk("async_rst_req", {6'b0, tile_int_req}, 8'h00);
        rst_n = 1'b0;
        tick(1);
        reg_rd(8'h00, rd); chk("rst_pend_clr", rd, 8'h00);
        reg_rd(8'h01, rd); chk("rst_enable_clr", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tile_irq_ctrl.md
Name: tile_irq_ctrl

Overview:
Tile-side interrupt source for the Dock interrupt fabric. It collects local event inputs, latches them as pending and applies per-event enable and channel mapping. It drives the level-sensitive tile_int_req/tile_nmi_req lines into the Dock IRQ router. It consumes the router's one-cycle slot_ack pulse by capturing an acknowledge vector that tile firmware or the CPU reads over a small register port.

Parameters:
NUM_EVENTS, 8, local event inputs (1..8)
NUM_TILE_INT_CH, 2, maskable request channels driven to the router (1..4)
NMI_EVT, 7, event index routed to tile_nmi_req instead of a maskable channel; value >= NUM_EVENTS disables the NMI path
CFG_ADDR_WIDTH, 8, register address width

Ports:
clk  in  1  clock
rst_n  in  1  reset
evt_in  in  NUM_EVENTS  asynchronous event sources, rising edge = event
tile_int_req  out  NUM_TILE_INT_CH  level request per channel to router
tile_nmi_req  out  1  level NMI request to router
slot_ack  in  1  one-cycle acknowledge pulse from router
cfg_wr_en  in  1  register write strobe
cfg_rd_en  in  1  register read strobe
cfg_addr  in  CFG_ADDR_WIDTH  register address
cfg_wdata  in  8  write data
cfg_rdata  out  8  read data, registered
ack_state  out  1  1 = ACKED (vector valid, not yet retired)

Behaviour:
- Reset: rst_n, asynchronous, active-high; clock clk. All registers clear. Outputs tile_int_req=0, tile_nmi_req=0, cfg_rdata=0, ack_state=0. ENABLE=0, CHMAP=0, NMI_EN=0.
- Sync/edge detection:
  - evt_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge sets PENDING[e] on the following clock, so the edge is visible in PENDING 3 clk after the input rises.
  - Level-high inputs do not re-set a cleared bit until the next rising edge.
- Registers (8-bit, unused high bits read 0):
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x01 ENABLE: read/write.
  - 0x02 VECTOR: read-only; bit7 = valid, [6:4] = channel, [3:0] = event.
  - 0x03 CTRL: bit0 NMI_EN.
  - 0x10+e CHMAP[e]: bits[1:0] channel.
  - CHMAP values >= NUM_TILE_INT_CH: event never drives any channel but stays pending and readable.
  - Unmapped addresses: reads return 0x00, writes are ignored.
- Read timing: cfg_rdata updates on the clock edge where cfg_rd_en=1, i.e. 1-cycle latency; it holds otherwise.
- Request generation (registered, 1-cycle after the PENDING/ENABLE/CHMAP change):
  - tile_int_req[c] = OR over e != NMI_EVT of (PENDING[e] & ENABLE[e] & CHMAP[e]==c).
  - tile_nmi_req = PENDING[NMI_EVT] & NMI_EN.
- Set/clear collision: a W1C and an edge on the same bit in the same cycle leaves the bit set.
- FSM states IDLE, ACKED:
  - IDLE -> ACKED on slot_ack with any tile_int_req bit high. VECTOR captures the lowest asserted channel c, plus the lowest-index enabled pending event mapped to c. Selection uses pre-write PENDING if a W1C lands in the same cycle. valid=1.
  - slot_ack with no maskable request (NMI-only or idle): no capture, state unchanged.
  - ACKED -> IDLE when a cfg read of VECTOR occurs, or when the captured event's PENDING bit clears. valid drops in the same cycle as the transition.
  - slot_ack in ACKED re-captures VECTOR, which covers the case where the router re-acks the same request. State stays ACKED.
- Request lines hold in ACKED; deassertion is driven only by PENDING/ENABLE changes, since the router requires the tile to drop its request to retire.
- Reset mid-operation forces IDLE, clears PENDING, and drops requests asynchronously.

Optional Feature:
ACK_AUTOCLR_EN:
- Defined: on the IDLE->ACKED capture, the captured event's PENDING bit clears on the same edge. The channel request therefore drops 1 cycle later unless another enabled event maps to it. The FSM then exits ACKED only on a VECTOR read.
- Undefined: PENDING clears only by W1C.

Test Plan:
- Reset -> tile_int_req=00, tile_nmi_req=0, ack_state=0, reads of 0x00, 0x01 and 0x02 return 0x00.
- ENABLE=0x01, CHMAP[0]=0, evt_in[0] rises -> PENDING=0x01 after 3 clk; tile_int_req=01 on the next cycle. W1C 0x01 to 0x00 -> tile_int_req=00 one cycle later.
- ENABLE=0x06, CHMAP[1]=1, CHMAP[2]=1, evt_in[2] then evt_in[1] fire, slot_ack pulse -> VECTOR=0x91, ack_state=1. Read VECTOR -> 0x91 returned, ack_state=0.
- CTRL=0x01, evt_in[7] rises -> tile_nmi_req=1, tile_int_req=00. slot_ack pulse -> ack_state stays 0. With NMI_EN=0 the event stays pending and tile_nmi_req=0.
- CHMAP[3]=3, ENABLE=0x08, evt_in[3] fires -> PENDING=0x08, tile_int_req=00. Same-cycle W1C and evt edge on bit3 -> bit stays 1.
- ACK_AUTOCLR_EN defined, scenario 3 -> PENDING goes 0x06->0x04 at the ack, tile_int_req[1] stays 1 (event 2 still pending). Undefined -> PENDING stays 0x06.
